// File: rtl/scope_adc_ctrl.sv
// LTC2308 sampling controller: frame-rate timer plus a CONVST / 12-bit SPI
// transfer FSM that reports each result tagged with the channel it belongs to.
module scope_adc_ctrl #(
  parameter int CLK_DIV     = 2,
  parameter int CONV_CYCLES = 80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [2:0]  channel,
  input  logic [15:0] rate_div,
  output logic        ADC_CS_N,
  output logic        ADC_SCLK,
  output logic        ADC_DIN,
  input  logic        ADC_DOUT,
  output logic [11:0] sample_data,
  output logic [2:0]  sample_chan,
  output logic        sample_valid,
  output logic        overrun
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CONV_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(CONV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CONV, XFER, DONE} state_t;

  state_t             r_state;
  logic [15:0]        r_timer;
  logic [CONV_W-1:0]  r_conv_cnt;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [3:0]         r_bit;
  logic [11:0]        r_shift;
  logic [2:0]         r_cfg_cur;
  logic [2:0]         r_cfg_prev;
  logic               w_tick;
  logic [5:0]         w_cfg_word;
  logic               w_next_din;

  assign w_tick     = enable && (r_timer == '0);
  assign w_cfg_word = {1'b1, r_cfg_cur[0], r_cfg_cur[2], r_cfg_cur[1], 1'b1, 1'b0};

  // Config bit for the bit period that follows the current one.
  always_comb begin
    w_next_din = 1'b0;
    if (r_bit < 4'd5)
      w_next_din = w_cfg_word[3'd4 - r_bit[2:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_timer <= rate_div;
    else if (!enable || r_timer == '0)
      r_timer <= rate_div;
    else
      r_timer <= r_timer - 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_conv_cnt   <= '0;
      r_div_cnt    <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_cfg_cur    <= '0;
      r_cfg_prev   <= '0;
      ADC_CS_N     <= 1'b0;
      ADC_SCLK     <= 1'b0;
      ADC_DIN      <= 1'b0;
      sample_data  <= '0;
      sample_chan  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (!enable)
        overrun <= 1'b0;
      else if (w_tick && r_state != IDLE)
        overrun <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_tick) begin
            r_state    <= CONV;
            r_cfg_cur  <= channel;
            r_conv_cnt <= '0;
            ADC_CS_N   <= 1'b1;
          end
        end
        CONV: begin
          if (r_conv_cnt == CONV_LAST) begin
            r_state   <= XFER;
            r_div_cnt <= '0;
            r_bit     <= '0;
            ADC_CS_N  <= 1'b0;
            ADC_SCLK  <= 1'b0;
            ADC_DIN   <= w_cfg_word[5];
          end else begin
            r_conv_cnt <= r_conv_cnt + CONV_W'(1);
          end
        end
        XFER: begin
          if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= '0;
            if (!ADC_SCLK) begin
              ADC_SCLK <= 1'b1;
              r_shift  <= {r_shift[10:0], ADC_DOUT};
            end else if (r_bit == 4'd11) begin
              ADC_SCLK     <= 1'b0;
              ADC_DIN      <= 1'b0;
              r_state      <= DONE;
              sample_valid <= 1'b1;
              sample_data  <= r_shift;
              sample_chan  <= r_cfg_prev;
              r_cfg_prev   <= r_cfg_cur;
            end else begin
              ADC_SCLK <= 1'b0;
              ADC_DIN  <= w_next_din;
              r_bit    <= r_bit + 4'd1;
            end
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scope_adc_ctrl.sv
// Bench for scope_adc_ctrl: frame-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_scope_adc_ctrl;

  localparam int CD   = 2;
  localparam int CONV = 80;
  localparam int L    = CONV + 24 * CD;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [2:0]  channel;
  logic [15:0] rate_div;
  logic        ADC_CS_N;
  logic        ADC_SCLK;
  logic        ADC_DIN;
  logic        ADC_DOUT;
  logic [11:0] sample_data;
  logic [2:0]  sample_chan;
  logic        sample_valid;
  logic        overrun;

  scope_adc_ctrl #(.CLK_DIV(CD), .CONV_CYCLES(CONV)) dut (
    .clk(clk), .reset(reset), .enable(enable), .channel(channel),
    .rate_div(rate_div), .ADC_CS_N(ADC_CS_N), .ADC_SCLK(ADC_SCLK),
    .ADC_DIN(ADC_DIN), .ADC_DOUT(ADC_DOUT), .sample_data(sample_data),
    .sample_chan(sample_chan), .sample_valid(sample_valid), .overrun(overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;
  int n_valid = 0;
  int cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait budget expired at cycle %0d", name, cyc);
  endtask

  // ADC stand-in: presents result bit 11-k during bit k; logs DIN at each SCLK rise.
  logic [11:0] adc_word;
  logic [11:0] din_seq;
  int          adc_k;
  logic        sclk_prev;
  initial begin
    adc_word  = '0;
    din_seq   = '0;
    adc_k     = 0;
    sclk_prev = 1'b0;
    ADC_DOUT  = 1'b0;
  end
  always @(posedge clk) begin
    #1;
    if (reset || ADC_CS_N) begin
      adc_k   = 0;
      din_seq = '0;
    end else if (ADC_SCLK && !sclk_prev) begin
      din_seq = {din_seq[10:0], ADC_DIN};
      adc_k++;
    end
    sclk_prev = ADC_SCLK;
    ADC_DOUT  = (adc_k < 12) ? adc_word[11 - adc_k] : 1'b0;
  end

  // Reference model: tick schedule and frame start times, outputs derived from frame offset.
  logic        armed, busy, m_ov;
  int          next_tick, f_start;
  logic [2:0]  f_ch, m_prev, m_chan;
  logic [11:0] f_word, m_data;
  initial begin
    armed = 0; busy = 0; m_ov = 0; next_tick = 0; f_start = 0;
    f_ch = 0; m_prev = 0; m_chan = 0; f_word = 0; m_data = 0;
  end

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      armed = 0; busy = 0; m_ov = 0; m_prev = 0; m_chan = 0; m_data = 0;
    end else begin
      logic tick;
      tick = 0;
      if (busy && (cyc - f_start) >= L + 2) busy = 0;
      if (!enable) begin
        armed = 0;
        m_ov  = 0;
      end else begin
        if (!armed) begin
          armed     = 1;
          next_tick = cyc + int'(rate_div);
        end
        if (cyc == next_tick) begin
          tick      = 1;
          next_tick = cyc + int'(rate_div) + 1;
        end
      end
      if (tick) begin
        if (busy) m_ov = 1;
        else begin
          busy = 1; f_start = cyc; f_ch = channel; f_word = adc_word;
        end
      end
      if (busy && (cyc - f_start) == L) begin
        m_data = f_word;
        m_chan = m_prev;
        m_prev = f_ch;
      end
    end
  end

  always @(negedge clk) begin
    int o, x, k;
    logic [5:0] cw;
    logic e_cs, e_sclk, e_din, e_valid, e_ov;
    logic [11:0] e_data;
    logic [2:0] e_chan;
    e_cs = 0; e_sclk = 0; e_din = 0; e_valid = 0;
    e_data = m_data; e_chan = m_chan; e_ov = m_ov;
    if (reset) begin
      e_data = '0; e_chan = '0; e_ov = 0;
    end else if (busy) begin
      o = cyc - f_start;
      if (o < CONV) e_cs = 1;
      else if (o < L) begin
        x      = o - CONV;
        k      = x / (2 * CD);
        e_sclk = (x % (2 * CD)) >= CD;
        cw     = {1'b1, f_ch[0], f_ch[2], f_ch[1], 1'b1, 1'b0};
        e_din  = (k < 6) ? cw[5 - k] : 1'b0;
      end else if (o == L) e_valid = 1;
    end
    chk("cs_n",  int'(ADC_CS_N),     int'(e_cs));
    chk("sclk",  int'(ADC_SCLK),     int'(e_sclk));
    chk("din",   int'(ADC_DIN),      int'(e_din));
    chk("valid", int'(sample_valid), int'(e_valid));
    chk("data",  int'(sample_data),  int'(e_data));
    chk("chan",  int'(sample_chan),  int'(e_chan));
    chk("ovr",   int'(overrun),      int'(e_ov));
    if (sample_valid) n_valid++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input string name, input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sample_valid) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) timeout(name);
  endtask

  task automatic wait_cs(input string name, input logic val, input int budget);
    logic seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ADC_CS_N == val) begin
        seen = 1;
        break;
      end
    end
    if (!seen) timeout(name);
  endtask

  initial begin
    int e0, t1, t2, t3, v0, rises;
    logic prev;
    reset = 1; enable = 0; channel = 0; rate_div = 16'd199;
    step(3);
    chk("rst_cs", int'(ADC_CS_N), 0);
    chk("rst_data", int'(sample_data), 0);
    chk("rst_ovr", int'(overrun), 0);
    reset = 0;

    // Continuous sampling, channel 5, result 0xA5C
    channel = 3'd5; adc_word = 12'hA5C;
    step(2);
    enable = 1; e0 = cyc + 1;
    wait_valid("a_first", 400, t1);
    chk("a_latency", t1 - e0, 327);
    chk("a_data1", int'(sample_data), 'hA5C);
    chk("a_chan1", int'(sample_chan), 0);
    chk("a_din_seq", int'(din_seq), 'hE80);
    wait_valid("a_second", 300, t2);
    chk("a_period", t2 - t1, 200);
    chk("a_chan2", int'(sample_chan), 5);
    chk("a_data2", int'(sample_data), 'hA5C);
    step(1);
    adc_word = 12'h3F1; channel = 3'd2;
    wait_valid("a_third", 300, t3);
    chk("a_data3", int'(sample_data), 'h3F1);
    chk("a_chan3", int'(sample_chan), 5);
    step(1);
    enable = 0;
    step(5);

    // Enable dropped during conversion: exactly one more sample
    rate_div = 16'd9;
    step(2);
    enable = 1;
    wait_cs("b_conv", 1'b1, 50);
    step(5);
    enable = 0; v0 = n_valid;
    step(400);
    chk("b_valids", n_valid - v0, 1);
    chk("b_cs_idle", int'(ADC_CS_N), 0);

    // Frame period shorter than a frame: overrun
    rate_div = 16'd50; adc_word = 12'h000;
    step(2);
    enable = 1;
    wait_valid("c_first", 300, t1);
    chk("c_ovr_set", int'(overrun), 1);
    step(1);
    enable = 0;
    step(2);
    chk("c_ovr_clr", int'(overrun), 0);
    step(200);
    chk("c_idle_cs", int'(ADC_CS_N), 0);
    chk("c_idle_sclk", int'(ADC_SCLK), 0);

    // Reset during bit 7 of a transfer
    rate_div = 16'd19; adc_word = 12'hFFF; channel = 3'd7;
    step(2);
    enable = 1;
    wait_cs("d_conv", 1'b1, 60);
    wait_cs("d_xfer", 1'b0, 200);
    rises = 0; prev = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ADC_SCLK && !prev) rises++;
      prev = ADC_SCLK;
      if (rises == 7 && !ADC_SCLK) break;
    end
    chk("d_bit7_reached", rises, 7);
    #1 reset = 1;
    #1;
    chk("d_rst_cs", int'(ADC_CS_N), 0);
    chk("d_rst_sclk", int'(ADC_SCLK), 0);
    chk("d_rst_din", int'(ADC_DIN), 0);
    chk("d_rst_data", int'(sample_data), 0);
    chk("d_rst_valid", int'(sample_valid), 0);
    v0 = n_valid;
    step(3);
    reset = 0; e0 = cyc + 1;
    wait_valid("d_after", 300, t1);
    chk("d_latency", t1 - e0, 147);
    chk("d_data", int'(sample_data), 'hFFF);
    chk("d_chan", int'(sample_chan), 0);
    step(1);
    chk("d_one_valid", n_valid - v0, 1);
    enable = 0;
    step(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
